// File: rtl/count_bcd_converter.sv
// count_bcd_converter
// Converts the binary up/down counter value into packed BCD digits using a
// sequential shift-add-3 (double-dabble) engine that retires one bit per clock.
// A conversion is launched from IDLE by a start pulse or, when AUTO is set, by
// any difference between the live count and the last value converted.
module count_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit AUTO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      count,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  busy
);

  localparam int DW = 4 * DIGITS;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH);

  // Integer power used only for the elaboration-time range check below.
  function automatic longint unsigned pow_u(input int unsigned base, input int unsigned e);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < e; i++) begin
      r = r * base;
    end
    return r;
  endfunction

  // Enough decimal digits must exist to hold the largest binary count.
  if ((WIDTH < 1) || (WIDTH > 16) || (pow_u(10, DIGITS) < pow_u(2, WIDTH))) begin : g_bad_params
    $error("count_bcd_converter: WIDTH must be 1..16 and 10**DIGITS >= 2**WIDTH");
  end

  // Double-dabble correction: every digit of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  // The corrected value never exceeds 12, so 4-bit arithmetic cannot overflow.
  function automatic logic [DW-1:0] add3_digits(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = d[4*i +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_sr_q, bin_sr_d;
  logic [DW-1:0]     dig_sr_q, dig_sr_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]  last_count_q, last_count_d;
  logic [DW-1:0]     bcd_q, bcd_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              trigger_s;
  logic [DW-1:0]     adj_s;

  // A start request and an auto-detected change collapse into one trigger.
  assign trigger_s = start | ((AUTO == 1'b1) && (count != last_count_q));

  // Next-state logic for the converter sequencer and its datapath registers.
  always_comb begin
    state_d      = state_q;
    bin_sr_d     = bin_sr_q;
    dig_sr_d     = dig_sr_q;
    bitcnt_d     = bitcnt_q;
    last_count_d = last_count_q;
    bcd_d        = bcd_q;
    valid_d      = 1'b0;
    adj_s        = add3_digits(dig_sr_q);

    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          bin_sr_d     = count;
          last_count_d = count;
          dig_sr_d     = {DW{1'b0}};
          bitcnt_d     = BIT_LOAD;
          state_d      = ST_SHIFT;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {dig_sr_d, bin_sr_d} = {adj_s, bin_sr_q} << 1'b1;
        bitcnt_d = bitcnt_q - BIT_ONE;
        if (bitcnt_q == BIT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        bcd_d   = dig_sr_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bin_sr_q     <= {WIDTH{1'b0}};
      dig_sr_q     <= {DW{1'b0}};
      bitcnt_q     <= {BW{1'b0}};
      last_count_q <= {WIDTH{1'b0}};
      bcd_q        <= {DW{1'b0}};
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_sr_q     <= bin_sr_d;
      dig_sr_q     <= dig_sr_d;
      bitcnt_q     <= bitcnt_d;
      last_count_q <= last_count_d;
      bcd_q        <= bcd_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule
